dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Control stage directly upstream of the 2-way, 16-set, 256-bit-line data-cache SRAM.
- Accepts 32-bit CPU load/store requests and splits each address into tag, index and word offset.
- Drives the SRAM lookup/write port and merges store words into lines.
- On a miss: stalls the CPU, writes back a dirty victim, refills from memory, then replays the access.

Parameters:
- ADDR_W, 32, CPU/memory byte address width
- WORD_W, 32, CPU data word width
- LINE_W, 256, cache line width (8 words, 32 bytes)
- IDX_W, 4, set index width (16 sets)
- TAG_W, 23, address tag width (ADDR_W-IDX_W-5)

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low: sampled on rising edge of clk_i when 0
- cpu_addr_i  in  32  byte address; [31:9] tag, [8:5] index, [4:2] word select, [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request and pipeline
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  hit or victim tag
- sram_data_i  in  256  hit or victim line
- sram_hit_i  in  1  lookup hit
- mem_addr_o  out  32  line-aligned address, [4:0]=0
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write (1) / read (0)
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Request is active when cpu_MemRead_i or cpu_MemWrite_i is 1. Both asserted together are treated as a store.
- Reset values: state=IDLE; cpu_stall_o=0; cpu_data_o=0; all mem_* and sram_enable_o/sram_write_o=0; refill line register=0.
- Outside IDLE, SRAM outputs are registered controls.
- Tag word layout: bit24 valid, bit23 dirty, [22:0] tag.
- IDLE:
  - With a request: sram_enable_o=1, sram_addr_o=index, sram_tag_o={1,0,tag}.
  - Read hit: cpu_data_o = sram_data_i[32*w+:32] combinationally in the same cycle; cpu_stall_o=0; zero-cycle latency.
  - Write hit: same cycle, sram_write_o=1, sram_data_o = hit line with word w replaced by cpu_data_i, sram_tag_o={1,1,tag}; cpu_stall_o=0.
  - Miss (sram_hit_i=0): cpu_stall_o=1 combinationally; next state MISS.
- SRAM contract on miss: sram_tag_i/sram_data_i present the LRU victim way.
- MISS:
  - Victim valid and dirty: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; go to WRITEBACK.
  - Otherwise: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; go to REFILL.
- WRITEBACK: hold mem_* stable until mem_ack_i. On ack, switch to a read of the CPU line's address and go to REFILL.
- REFILL: hold the read request until mem_ack_i. On ack, capture mem_data_i, drop mem_enable_o, go to FILL.
- FILL:
  - One cycle: sram_enable_o=1, sram_write_o=1, sram_data_o=captured line, sram_tag_o={1,0,tag}.
  - For a store, word w is pre-merged and the tag is {1,1,tag}.
  - Go to DONE.
- DONE:
  - One cycle: re-lookup (guaranteed hit).
  - Load: cpu_data_o driven from the lookup.
  - cpu_stall_o=0 this cycle; return to IDLE.
- cpu_stall_o=1 in MISS, WRITEBACK, REFILL and FILL.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Request withdrawn mid-miss: refill still completes, no CPU-visible effect.
- Reset mid-operation: return to IDLE immediately and deassert mem_enable_o; the memory model tolerates an abandoned request.

Decomposition:
- Shared package dcache_pkg:
  - constants TAG_W, IDX_W, LINE_W, VALID_BIT=24, DIRTY_BIT=23
  - state enum {IDLE, MISS, WRITEBACK, REFILL, FILL, DONE}
  - address field slicing functions
- One sub-module: dcache_word_merge. Combinational: line, word index, word -> merged line. Also used for read word select.

Test Plan:
- Cold load 0x0000_0124: stall asserted, clean victim, so a memory read at 0x0000_0120 with no write-back. After ack: FILL then DONE. cpu_data_o = word 1 of refill line. Stall drops in DONE.
- Repeat load 0x0000_0124: hit, no stall, data in the same cycle, mem_enable_o stays 0.
- Store 0xDEADBEEF to 0x0000_0128: hit. SRAM write line has word 2=0xDEADBEEF and tag bit23=1; stall stays 0.
- Fill both ways of index 9 with lines A and B (A dirty), then miss on a third tag:
  - write-back of A's line at {A tag, 9, 0} with the dirty data
  - followed by a read of the new address
  - mem_write_o 1 then 0
- Memory ack delayed 20 cycles: mem_addr_o/mem_data_o/mem_enable_o stable throughout; stall held.
- rst_i=0 during REFILL: next edge state=IDLE, mem_enable_o=0, cpu_stall_o=0. A later request misses cleanly.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the data-cache control stage.
// Tag words are {valid, dirty, tag}; lines are 8 words of 32 bits.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int IDX_W     = 4;
    localparam int OFF_W     = 5;
    localparam int SEL_W     = 3;
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int STAG_W    = TAG_W + 2;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        FILL,
        DONE
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: SEL_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx
    );
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU, SRAM and memory signals of the data-cache control stage.
// master is the controller view, slave the surrounding environment.
interface dcache_if;
    import dcache_pkg::*;

    logic [ADDR_W-1:0] cpu_addr_i;
    logic [WORD_W-1:0] cpu_data_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [WORD_W-1:0] cpu_data_o;
    logic              cpu_stall_o;

    logic [IDX_W-1:0]  sram_addr_o;
    logic [STAG_W-1:0] sram_tag_o;
    logic [LINE_W-1:0] sram_data_o;
    logic              sram_enable_o;
    logic              sram_write_o;
    logic [STAG_W-1:0] sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_hit_i;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        output sram_addr_o, sram_tag_o, sram_data_o,
        output sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_addr_o, sram_tag_o, sram_data_o,
        input  sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/dcache_word_merge.sv
// Replaces one word of a cache line and extracts the same word
// from the unmodified line.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [LINE_W-1:0] line_o,
    output logic [WORD_W-1:0] word_o
);

    always_comb begin
        line_o = line_i;
        line_o[WORD_W*sel_i +: WORD_W] = word_i;
    end

    assign word_o = line_i[WORD_W*sel_i +: WORD_W];

endmodule

// File: rtl/dcache_controller.sv
// Data-cache control stage: hit path in IDLE, miss handling with
// write-back, refill, fill and replay of the stalled access.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.master bus
);

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [SEL_W-1:0]  sel_q;
    logic [WORD_W-1:0] data_q;
    logic              store_q;
    logic [STAG_W-1:0] vtag_q;
    logic [LINE_W-1:0] vline_q;
    logic [LINE_W-1:0] line_q;

    logic              req, store, idle, vdirty;
    logic [LINE_W-1:0] m_line, m_merged;
    logic [SEL_W-1:0]  m_sel;
    logic [WORD_W-1:0] m_in, m_word;

    assign req    = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign store  = bus.cpu_MemWrite_i;
    assign idle   = (state_q == IDLE);
    assign vdirty = vtag_q[VALID_BIT] & vtag_q[DIRTY_BIT];

    // IDLE merges into the hit line; FILL merges into the refilled line
    assign m_line = (state_q == FILL) ? line_q : bus.sram_data_i;
    assign m_sel  = idle ? addr_word(bus.cpu_addr_i) : sel_q;
    assign m_in   = idle ? bus.cpu_data_i : data_q;

    dcache_word_merge u_merge (
        .line_i (m_line),
        .sel_i  (m_sel),
        .word_i (m_in),
        .line_o (m_merged),
        .word_o (m_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            store_q <= 1'b0;
            vtag_q  <= '0;
            vline_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (idle && req && !bus.sram_hit_i) begin
                tag_q   <= addr_tag(bus.cpu_addr_i);
                idx_q   <= addr_idx(bus.cpu_addr_i);
                sel_q   <= addr_word(bus.cpu_addr_i);
                data_q  <= bus.cpu_data_i;
                store_q <= store;
                vtag_q  <= bus.sram_tag_i;
                vline_q <= bus.sram_data_i;
            end
            if (state_q == REFILL && bus.mem_ack_i) begin
                line_q <= bus.mem_data_i;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.cpu_data_o    = '0;
        bus.cpu_stall_o   = 1'b0;
        bus.sram_addr_o   = idx_q;
        bus.sram_tag_o    = '0;
        bus.sram_data_o   = '0;
        bus.sram_enable_o = 1'b0;
        bus.sram_write_o  = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_data_o    = '0;
        bus.mem_enable_o  = 1'b0;
        bus.mem_write_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.sram_addr_o = addr_idx(bus.cpu_addr_i);
                if (req) begin
                    bus.sram_enable_o = 1'b1;
                    bus.sram_tag_o = {2'b10, addr_tag(bus.cpu_addr_i)};
                    if (!bus.sram_hit_i) begin
                        bus.cpu_stall_o = 1'b1;
                        state_d = MISS;
                    end else if (store) begin
                        bus.sram_write_o = 1'b1;
                        bus.sram_data_o  = m_merged;
                        bus.sram_tag_o = {2'b11, addr_tag(bus.cpu_addr_i)};
                    end else begin
                        bus.cpu_data_o = m_word;
                    end
                end
            end
            MISS: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                if (vdirty) begin
                    bus.mem_write_o = 1'b1;
                    bus.mem_addr_o = line_addr(vtag_q[TAG_W-1:0], idx_q);
                    bus.mem_data_o = vline_q;
                    state_d = WRITEBACK;
                end else begin
                    bus.mem_addr_o = line_addr(tag_q, idx_q);
                    state_d = REFILL;
                end
            end
            WRITEBACK: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o = line_addr(vtag_q[TAG_W-1:0], idx_q);
                bus.mem_data_o = vline_q;
                if (bus.mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o = line_addr(tag_q, idx_q);
                if (bus.mem_ack_i) state_d = FILL;
            end
            FILL: begin
                bus.cpu_stall_o   = 1'b1;
                bus.sram_enable_o = 1'b1;
                bus.sram_write_o  = 1'b1;
                bus.sram_data_o   = store_q ? m_merged : line_q;
                bus.sram_tag_o    = {1'b1, store_q, tag_q};
                state_d = DONE;
            end
            DONE: begin
                bus.sram_enable_o = 1'b1;
                bus.sram_tag_o    = {2'b10, tag_q};
                if (!store_q) bus.cpu_data_o = m_word;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
